// File: rtl/adc_spi_responder.sv
// MCP3202-style SPI ADC responder: decodes start/SGL/ODD/MSBF, returns null bit then the 12-bit sample.
// Pin edges reach the FSM after SYNC_STAGES+1 clk; miso updates on the clk the synced SCK fall registers.
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              cs,
   input  logic              mosi,
   input  logic [DATA_W-1:0] ch0_sample,
   input  logic [DATA_W-1:0] ch1_sample,
   output logic              miso,
   output logic              miso_oe,
   output logic              cfg_sgl,
   output logic              cfg_odd,
   output logic              cfg_msbf,
   output logic              cfg_valid,
   output logic              frame_done,
   output logic              frame_error
);

   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_START = 3'd1;
   localparam logic [2:0] S_CONFIG     = 3'd2;
   localparam logic [2:0] S_NULL_BIT   = 3'd3;
   localparam logic [2:0] S_DATA_MSB   = 3'd4;
   localparam logic [2:0] S_DATA_LSB   = 3'd5;
   localparam logic [2:0] S_TRAIL      = 3'd6;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_d;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall;

   logic [2:0]        state;
   logic [1:0]        bit_cnt;
   logic [IDX_W-1:0]  idx;
   logic              last_bit;
   logic              rise_seen;
   logic              cmd_sgl, cmd_odd;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] sample_sel;

   // cs resets to the deasserted level so a reset never looks like a frame start
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sck_d     <= sck_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;

   // Differential modes use a one-bit-wider subtraction; a borrow clamps to zero
   always_comb begin
      diff = cmd_odd ? ({1'b0, ch1_sample} - {1'b0, ch0_sample})
                     : ({1'b0, ch0_sample} - {1'b0, ch1_sample});
      if (cmd_sgl)
         sample_sel = cmd_odd ? ch1_sample : ch0_sample;
      else if (diff[DATA_W])
         sample_sel = '0;
      else
         sample_sel = diff[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         idx         <= '0;
         last_bit    <= 1'b0;
         rise_seen   <= 1'b0;
         cmd_sgl     <= 1'b0;
         cmd_odd     <= 1'b0;
         shift_reg   <= '0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         cfg_sgl     <= 1'b0;
         cfg_odd     <= 1'b0;
         cfg_msbf    <= 1'b0;
         cfg_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         cfg_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frame_error <= 1'b0;
         if (state != S_IDLE && cs_s) begin
            state   <= S_IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            if ((state == S_WAIT_START && rise_seen) || state == S_CONFIG ||
                state == S_NULL_BIT || state == S_DATA_MSB || state == S_DATA_LSB)
               frame_error <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
                  if (!cs_s) begin
                     state     <= S_WAIT_START;
                     rise_seen <= 1'b0;
                  end
               end
               S_WAIT_START: begin
                  if (sck_rise) begin
                     rise_seen <= 1'b1;
                     if (mosi_s) begin
                        state   <= S_CONFIG;
                        bit_cnt <= '0;
                     end
                  end
               end
               S_CONFIG: begin
                  if (sck_rise) begin
                     bit_cnt <= bit_cnt + 2'd1;
                     case (bit_cnt)
                        2'd0:    cmd_sgl <= mosi_s;
                        2'd1:    cmd_odd <= mosi_s;
                        default: begin
                           cfg_sgl   <= cmd_sgl;
                           cfg_odd   <= cmd_odd;
                           cfg_msbf  <= mosi_s;
                           cfg_valid <= 1'b1;
                           shift_reg <= sample_sel;
                           state     <= S_NULL_BIT;
                        end
                     endcase
                  end
               end
               S_NULL_BIT: begin
                  if (sck_fall) begin
                     miso     <= 1'b0;
                     miso_oe  <= 1'b1;
                     idx      <= IDX_W'(DATA_W - 1);
                     last_bit <= 1'b0;
                     state    <= S_DATA_MSB;
                  end
               end
               S_DATA_MSB: begin
                  if (sck_fall) begin
                     if (last_bit) begin
                        if (cfg_msbf) begin
                           miso       <= 1'b0;
                           frame_done <= 1'b1;
                           state      <= S_TRAIL;
                        end else begin
                           // B0 is not repeated: the LSB-first tail starts at B1
                           miso     <= shift_reg[1];
                           idx      <= IDX_W'(2);
                           last_bit <= 1'b0;
                           state    <= S_DATA_LSB;
                        end
                     end else begin
                        miso <= shift_reg[idx];
                        if (idx == '0)
                           last_bit <= 1'b1;
                        else
                           idx <= idx - 1'b1;
                     end
                  end
               end
               S_DATA_LSB: begin
                  if (sck_fall) begin
                     if (last_bit) begin
                        miso       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_TRAIL;
                     end else begin
                        miso <= shift_reg[idx];
                        if (idx == IDX_W'(DATA_W - 1))
                           last_bit <= 1'b1;
                        else
                           idx <= idx + 1'b1;
                     end
                  end
               end
               S_TRAIL: begin
                  miso    <= 1'b0;
                  miso_oe <= 1'b1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

- SPI slave that emulates the MCP3202-style 12-bit ADC on the far end of the SPI master's link.
- Decodes the master's start/SGL/ODD/MSBF command and serialises the selected 12-bit sample on `miso`, using the same frame the master expects: null bit, then B11..B0.
- Used as the bench/loopback ADC model and as an on-chip ADC stand-in fed by a sample source.

## Interface
- `DATA_W`, 12 — sample width.
- `SYNC_STAGES`, 2 — synchroniser depth on `sck`, `cs`, `mosi` (min 2).
- `clk`  in  1  — system clock; all logic rises on it.
- `rst`  in  1  — synchronous, active-high reset.
- `sck`  in  1  — SPI clock from master, asynchronous, idle low (mode 0).
- `cs`  in  1  — chip select, active low, asynchronous.
- `mosi`  in  1  — command bits from master.
- `ch0_sample`  in  DATA_W  — channel-0 value.
- `ch1_sample`  in  DATA_W  — channel-1 value.
- `miso`  out  1  — serial data to master.
- `miso_oe`  out  1  — high while `miso` is driven; the pad tri-states when low.
- `cfg_sgl`, `cfg_odd`, `cfg_msbf`  out  1 each  — last decoded command bits.
- `cfg_valid`  out  1  — one-`clk` pulse when MSBF is captured.
- `frame_done`  out  1  — one-`clk` pulse when the last data bit's period ends.
- `frame_error`  out  1  — one-`clk` pulse when `cs` rises mid-frame.

## Operation
**Input conditioning**
- `sck`, `cs`, `mosi` pass through `SYNC_STAGES` flops, then one edge-detect register.
- `sck_rise`/`sck_fall` are single-`clk` events.

**States**
- IDLE
  - `miso`=0, `miso_oe`=0.
  - Synced `cs` low → WAIT_START.
- WAIT_START
  - On each `sck_rise`, sample `mosi`.
  - `mosi`=0: leading zero, stay.
  - `mosi`=1: start bit → CONFIG with bit count = 0.
- CONFIG
  - On each `sck_rise`, capture in order SGL, ODD, MSBF.
  - At the MSBF capture:
    - latch `cfg_*`;
    - pulse `cfg_valid`;
    - latch the sample into `shift_reg` (selection rules below);
    - → NULL_BIT.
- NULL_BIT
  - On the next `sck_fall`: `miso`=0, `miso_oe`=1.
  - Then → DATA_MSB with bit index = DATA_W−1.
- DATA_MSB
  - On each `sck_fall`, drive `shift_reg[idx]`, then decrement `idx`.
  - At the `sck_fall` after B0 has been driven:
    - `cfg_msbf`=1 → TRAIL, pulse `frame_done`;
    - `cfg_msbf`=0 → DATA_LSB with idx=1, and drive B1 on that same edge.
- DATA_LSB
  - On each `sck_fall`, drive `shift_reg[idx]`, increment `idx` up to DATA_W−1.
  - At the `sck_fall` after B(DATA_W−1): `miso`=0, pulse `frame_done`, → TRAIL.
- TRAIL
  - `miso`=0, `miso_oe`=1.
  - Further SCK edges are ignored.

**Sample selection** (latched once per frame; input changes afterwards do not affect the frame)
- SGL=1: ODD=0 → `ch0_sample`; ODD=1 → `ch1_sample`.
- SGL=0: ODD=0 → `ch0_sample − ch1_sample`; ODD=1 → `ch1_sample − ch0_sample`.
  - Compute the difference DATA_W+1 bits wide; a negative result clamps to 0.
  - No wrap-around permitted.

**Abort and reset**
- Synced `cs` high in any non-IDLE state: next `clk` → IDLE, `miso`=0, `miso_oe`=0.
  - Pulse `frame_error` if the state was WAIT_START with ≥1 SCK rise seen, CONFIG, NULL_BIT, DATA_MSB or DATA_LSB.
  - No `frame_error` from TRAIL or from WAIT_START with no SCK rise seen.
- `cs` high takes precedence over a simultaneous SCK event in the same `clk`.
- `rst`: next `clk` → IDLE, regardless of pins.
  - `miso`=0, `miso_oe`=0.
  - `cfg_sgl`=`cfg_odd`=`cfg_msbf`=0.
  - `cfg_valid`=`frame_done`=`frame_error`=0.
  - `shift_reg`=0, counters=0.

## Timing
**Latency**
- Pin edge to internal event: `SYNC_STAGES`+1 `clk`.
- `miso` changes on the `clk` the `sck_fall` event is registered: 3 `clk` after the pin falls with defaults.
- `cfg_valid` pulses 3 `clk` after the SCK rise that carries MSBF.

**Master requirements**
- SCK high and low phases ≥ SYNC_STAGES+2 `clk` each.
- `cs` setup to first SCK rise ≥ SYNC_STAGES+2 `clk`.
- `cs` high ≥ SYNC_STAGES+2 `clk` between frames.

**Frame length**
- MSBF=1: 16 SCK falls after start (3 cfg + null + 12 data), counting the fall after the start bit.
- MSBF=0: 11 further falls for the LSB-first tail.

**Other**
- All outputs are registered.
- Single-cycle pulses never overlap for one frame.

## Test plan
- SGL=1, ODD=0, MSBF=1, `ch0_sample`=0xA5C, SCK half-period 88 `clk`:
  - master samples null 0, then 1010_0101_1100;
  - `cfg_valid` once; `frame_done` once; no `frame_error`.
- SGL=1, ODD=1, `ch1_sample`=0x001; change `ch1_sample` to 0xFFF right after `cfg_valid`:
  - serial word is 0x001.
- Differential cases:
  - SGL=0, ODD=0, ch0=0x300, ch1=0x100 → word 0x200;
  - SGL=0, ODD=1, same inputs → word 0x000 (clamped).
- MSBF=0, ch0=0x801:
  - MSB-first 1000_0000_0001, then LSB-first tail 0,0,0,0,0,0,0,0,0,0,1;
  - `miso`=0 afterwards.
- Abort: raise `cs` after 5 data bits:
  - `frame_error` one pulse, `miso_oe`=0 within SYNC_STAGES+2 `clk`;
  - the next full frame decodes correctly.
- Assert `rst` mid-DATA_MSB, with 2 leading zero bits before the start bit in the following frame:
  - all outputs at reset values the next `clk`;
  - the next frame ignores the zeros and returns the correct word.
